// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the fetch stage: opcode constants, BHT counter
// format and the fetch state encoding.
package inst_fetcher_pkg;

    // Major opcodes the decoder redirects on (JALR is left to the RoB).
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // 2-bit saturating counter; MSB is the taken prediction.
    localparam int unsigned     CNT_W   = 2;
    localparam logic [CNT_W-1:0] CNT_RST = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MIN = 2'b00;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    // Saturating increment on taken, decrement on not-taken.
    function automatic logic [CNT_W-1:0] cnt_update(
        input logic [CNT_W-1:0] cnt,
        input logic             taken
    );
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : CNT_W'(cnt + CNT_W'(1));
        end
        return (cnt == CNT_MIN) ? cnt : CNT_W'(cnt - CNT_W'(1));
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus: instruction-cache request/response and the decoder
// hand-off (buffered instruction, PC, prediction, consume/redirect).
//   master : fetch stage side
//   slave  : icache + decoder side
interface inst_fetcher_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_res;
    logic        issue_ready;
    logic        pc_change_flag;
    logic [31:0] pc_change;

    modport master (
        output icache_req, icache_addr, fetch_ready, inst, pc, pred_res,
        input  icache_valid, icache_data, issue_ready, pc_change_flag, pc_change
    );

    modport slave (
        input  icache_req, icache_addr, fetch_ready, inst, pc, pred_res,
        output icache_valid, icache_data, issue_ready, pc_change_flag, pc_change
    );
endinterface

// File: rtl/inst_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters.
//   clk_in/rst_in   : clock, synchronous active-high reset (all counters -> weakly not-taken)
//   lookup_idx      : combinational read index; lookup_taken_c = counter MSB
//   upd_en/upd_idx/upd_taken : synchronous training port
// A read and an update of the same entry in one cycle returns the old value.
module inst_fetcher_branch_predictor
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned BHT_BITS = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [BHT_BITS-1:0] lookup_idx,
    output logic                lookup_taken_c,
    input  logic                upd_en,
    input  logic [BHT_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int unsigned BHT_ENTRIES = 32'(1) << BHT_BITS;

    logic [CNT_W-1:0] bht_q [BHT_ENTRIES];
    logic [CNT_W-1:0] bht_d [BHT_ENTRIES];

    // Training: one counter moves per cycle.
    always_comb begin
        bht_d = bht_q;
        if (upd_en) begin
            bht_d[upd_idx] = cnt_update(bht_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    assign lookup_taken_c = bht_q[lookup_idx][CNT_W-1];

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: holds the fetch PC, issues single-outstanding icache requests,
// buffers one instruction for the decoder with its BHT prediction, follows
// decoder redirects and RoB flushes, and trains the BHT from RoB commits.
//   clk_in, rst_in (sync, active-high), rdy_in (global stall when low)
//   bus          : icache request/response and decoder hand-off
//   rob_clear*   : misprediction flush and corrected PC
//   rob_br_*     : resolved-branch training port
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned BHT_BITS = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    inst_fetcher_if.master        bus,
    input  logic                  rob_clear,
    input  logic [31:0]           rob_clear_pc,
    input  logic                  rob_br_valid,
    input  logic [31:0]           rob_br_pc,
    input  logic                  rob_br_taken
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  icache_addr_q, icache_addr_d;
    logic         icache_req_q, icache_req_d;
    logic         fetch_ready_q, fetch_ready_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  next_pc;
    logic         req_outstanding;
    logic         bht_taken_c;
    logic         unused_br_pc_bits;

    // Next state, request and buffer updates; nothing moves while rdy_in is low.
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        icache_addr_d   = icache_addr_q;
        icache_req_d    = icache_req_q;
        fetch_ready_d   = fetch_ready_q;
        inst_d          = inst_q;
        pc_d            = pc_q;
        next_pc         = 32'(pc_q + 32'd4);
        req_outstanding = 1'b0;

        if (rdy_in) begin
            if (rob_clear) begin
                // A request still waiting on its response must be drained first.
                case (state_q)
                    FETCH:   req_outstanding = icache_req_q & ~bus.icache_valid;
                    DROP:    req_outstanding = ~bus.icache_valid;
                    default: req_outstanding = 1'b0;
                endcase
                fetch_ready_d = 1'b0;
                fetch_pc_d    = rob_clear_pc;
                if (req_outstanding) begin
                    state_d = DROP;
                end else begin
                    state_d       = FETCH;
                    icache_req_d  = 1'b1;
                    icache_addr_d = rob_clear_pc;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        icache_req_d  = 1'b1;
                        icache_addr_d = fetch_pc_q;
                        // req_q is low only in the first cycle after reset.
                        if (icache_req_q && bus.icache_valid) begin
                            inst_d        = bus.icache_data;
                            pc_d          = fetch_pc_q;
                            fetch_ready_d = 1'b1;
                            icache_req_d  = 1'b0;
                            state_d       = HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.issue_ready) begin
                            if (bus.pc_change_flag) begin
                                next_pc = bus.pc_change;
                            end
                            fetch_pc_d    = next_pc;
                            icache_addr_d = next_pc;
                            icache_req_d  = 1'b1;
                            fetch_ready_d = 1'b0;
                            state_d       = FETCH;
                        end
                    end
                    DROP: begin
                        // Orphaned response: discard and start the real fetch.
                        if (bus.icache_valid) begin
                            icache_addr_d = fetch_pc_q;
                            icache_req_d  = 1'b1;
                            state_d       = FETCH;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            icache_addr_q <= RESET_PC;
            icache_req_q  <= 1'b0;
            fetch_ready_q <= 1'b0;
            inst_q        <= 32'h0;
            pc_q          <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            icache_addr_q <= icache_addr_d;
            icache_req_q  <= icache_req_d;
            fetch_ready_q <= fetch_ready_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
        end
    end

    inst_fetcher_branch_predictor #(
        .BHT_BITS (BHT_BITS)
    ) u_bp (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .lookup_idx     (pc_q[BHT_BITS+1:2]),
        .lookup_taken_c (bht_taken_c),
        .upd_en         (rdy_in & rob_br_valid),
        .upd_idx        (rob_br_pc[BHT_BITS+1:2]),
        .upd_taken      (rob_br_taken)
    );

    // Only the index bits of the training PC matter.
    assign unused_br_pc_bits = ^{rob_br_pc[31:BHT_BITS+2], rob_br_pc[1:0]};

    assign bus.icache_req  = icache_req_q;
    assign bus.icache_addr = icache_addr_q;
    assign bus.fetch_ready = fetch_ready_q;
    assign bus.inst        = inst_q;
    assign bus.pc          = pc_q;
    assign bus.pred_res    = fetch_ready_q & bht_taken_c;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: a behavioural icache + decoder + RoB
// drive the block; a queue of expected decoder-visible PCs and a BHT counter
// array model the intended behaviour, and a monitor checks each presentation.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          N_CYCLES = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;
    logic        rob_br_valid;
    logic [31:0] rob_br_pc;
    logic        rob_br_taken;

    inst_fetcher_if bus ();

    inst_fetcher #(
        .RESET_PC (RESET_PC),
        .BHT_BITS (8)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .bus          (bus),
        .rob_clear    (rob_clear),
        .rob_clear_pc (rob_clear_pc),
        .rob_br_valid (rob_br_valid),
        .rob_br_pc    (rob_br_pc),
        .rob_br_taken (rob_br_taken)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] exp_q[$];
    int          bht_m[256];
    logic [31:0] cur_pc    = 32'h0;
    int          presented = 0;
    bit          mon_on    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Instruction memory contents: unique per aligned address below 2^27.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = OPC_BRANCH;
            2'd1:    opc = OPC_JAL;
            2'd2:    opc = OPC_JALR;
            default: opc = 7'h13;
        endcase
        return {a[26:2], opc};
    endfunction

    function automatic int bht_index(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    function automatic logic [31:0] small_pc();
        return 32'($urandom_range(0, 63)) * 32'd4;
    endfunction

    // Monitor: each new presentation consumes one expected PC.
    initial begin
        bit prev_fr = 1'b0;
        int idle    = 0;
        logic [31:0] e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (bus.fetch_ready && !prev_fr) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_presentation: got pc %h expected none", bus.pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pc", bus.pc, e);
                    check("inst", bus.inst, mem_word(e));
                    cur_pc = e;
                    presented++;
                end
            end
            if (bus.fetch_ready) begin
                check("pred_res", 32'(bus.pred_res), 32'(bht_m[bht_index(cur_pc)] >= 2));
            end else begin
                check("pred_res_idle", 32'(bus.pred_res), 32'h0);
                idle++;
                if (idle > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL watchdog: got no presentation for %0d cycles required <=200", idle);
                    idle = 0;
                end
            end
            prev_fr = bus.fetch_ready;
        end
    end

    // Stimulus: icache, decoder and RoB behaviour plus model bookkeeping.
    initial begin
        bit          pending = 1'b0;
        int          lat     = 0;
        logic [31:0] paddr   = 32'h0;
        bit          rdy_p = 0, val_p = 0, clr_p = 0, iss_p = 0, flag_p = 0, br_p = 0, tkn_p = 0;
        logic [31:0] clr_pc_p = 0, tgt_p = 0, br_pc_p = 0;
        int          bi;

        rst = 1'b1;  rdy = 1'b1;
        rob_clear = 1'b0;  rob_clear_pc = 32'h0;
        rob_br_valid = 1'b0;  rob_br_pc = 32'h0;  rob_br_taken = 1'b0;
        bus.icache_valid = 1'b0;  bus.icache_data = 32'h0;
        bus.issue_ready = 1'b0;  bus.pc_change_flag = 1'b0;  bus.pc_change = 32'h0;
        for (int i = 0; i < 256; i++) bht_m[i] = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_icache_req", 32'(bus.icache_req), 32'h0);
        check("rst_pred_res", 32'(bus.pred_res), 32'h0);

        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(RESET_PC);
        mon_on = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk); #1;

            // Effects of the edge just taken.
            if (rdy_p) begin
                if (br_p) begin
                    bi = bht_index(br_pc_p);
                    if (tkn_p) bht_m[bi] = (bht_m[bi] < 3) ? bht_m[bi] + 1 : 3;
                    else       bht_m[bi] = (bht_m[bi] > 0) ? bht_m[bi] - 1 : 0;
                end
                if (clr_p) begin
                    exp_q.delete();
                    exp_q.push_back(clr_pc_p);
                end else if (iss_p) begin
                    exp_q.push_back(flag_p ? tgt_p : 32'(cur_pc + 32'd4));
                end
                if (val_p) pending = 1'b0;
            end

            // Request tracking.
            if (pending) begin
                check("req_held", 32'(bus.icache_req), 32'h1);
                check("addr_stable", bus.icache_addr, paddr);
            end else if (bus.icache_req) begin
                if (exp_q.size() != 0) check("req_addr", bus.icache_addr, exp_q[0]);
                else                   check("req_while_holding", 32'(bus.icache_req), 32'h0);
                pending = 1'b1;
                paddr   = bus.icache_addr;
                lat     = $urandom_range(0, 3);
            end

            // Cache response: repeats while rdy is low so it is never lost.
            bus.icache_valid = pending && (lat == 0);
            bus.icache_data  = bus.icache_valid ? mem_word(paddr) : $urandom;
            if (pending && lat > 0) lat--;

            rdy          = ($urandom_range(0, 9) != 0);
            rob_clear    = ($urandom_range(0, 19) == 0);
            rob_clear_pc = small_pc();
            bus.issue_ready    = bus.fetch_ready && ($urandom_range(0, 1) == 1);
            bus.pc_change_flag = bus.issue_ready && ($urandom_range(0, 2) == 0);
            bus.pc_change      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : small_pc();
            rob_br_valid = ($urandom_range(0, 3) == 0);
            rob_br_pc    = small_pc();
            rob_br_taken = ($urandom_range(0, 1) == 1);

            rdy_p = rdy;  val_p = bus.icache_valid;  clr_p = rob_clear;  clr_pc_p = rob_clear_pc;
            iss_p = bus.issue_ready;  flag_p = bus.pc_change_flag;  tgt_p = bus.pc_change;
            br_p = rob_br_valid;  br_pc_p = rob_br_pc;  tkn_p = rob_br_taken;
        end

        @(negedge clk);
        check("presentations", 32'(presented >= 100), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Fetch stage directly upstream of the decoder. Holds the fetch PC and issues single-outstanding requests to the instruction cache.
- Buffers one instruction plus its PC for the decoder, and supplies a 2-bit BHT branch prediction for it.
- Redirects on decoder-predicted jumps (JAL, taken-predicted branch) and on RoB misprediction clears.
- Trains the BHT from RoB branch commits.

Parameters:
- RESET_PC, 32'h0, PC fetched first after reset.
- BHT_BITS, 8, log2 of BHT entry count; index = pc[BHT_BITS+1:2].

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; all state frozen when low
- icache_req  out  1  fetch request valid
- icache_addr  out  32  fetch address, held stable while icache_req=1
- icache_valid  in  1  response for current request (one-cycle pulse)
- icache_data  in  32  instruction word, valid with icache_valid
- fetch_ready  out  1  inst/pc/pred_res valid for decoder
- inst  out  32  buffered instruction
- pc  out  32  PC of buffered instruction
- pred_res  out  1  BHT prediction for buffered instruction (1 = taken)
- issue_ready  in  1  decoder consumed buffered instruction this cycle
- pc_change_flag  in  1  decoder redirect (JAL / predicted-taken branch); only asserted with issue_ready
- pc_change  in  32  redirect target
- rob_clear  in  1  misprediction flush
- rob_clear_pc  in  32  correct PC after flush
- rob_br_valid  in  1  branch resolved, train BHT
- rob_br_pc  in  32  PC of resolved branch
- rob_br_taken  in  1  actual outcome

Behaviour:
- Reset values:
  - state = FETCH, fetch_pc = RESET_PC.
  - fetch_ready = 0, inst = 0, pc = 0, icache_req = 0 during the reset cycle.
  - All BHT counters = 2'b01 (weakly not-taken).
- rdy_in = 0: no register updates; icache_valid and issue_ready are ignored. icache_req and icache_addr hold their values.
- States:
  - FETCH: icache_req = 1, icache_addr = fetch_pc.
    - On icache_valid: inst <= icache_data, pc <= fetch_pc, fetch_ready <= 1, go to HOLD.
  - HOLD: icache_req = 0, fetch_ready = 1.
    - On issue_ready: fetch_ready <= 0, fetch_pc <= (pc_change_flag ? pc_change : pc+4), go to FETCH.
    - Otherwise hold all outputs stable (decoder stall).
  - DROP: an in-flight request has been orphaned by a flush. icache_req stays 1 with the old address.
    - On icache_valid: discard the data and go to FETCH with the already-loaded fetch_pc.
- Latency: minimum 2 cycles per instruction (request cycle, then HOLD cycle). Throughput is 1 instruction per 2 cycles when the cache hits every cycle.
- rob_clear has priority over every other event in the same cycle:
  - fetch_ready <= 0 and fetch_pc <= rob_clear_pc.
  - From FETCH: if icache_valid is also high that cycle, go to FETCH (the response is for the old request and is discarded); else go to DROP.
  - From HOLD or DROP: go to FETCH, or stay in DROP if a request is still outstanding.
  - issue_ready and pc_change_flag are ignored in the clear cycle.
- pred_res is combinational: BHT[pc index][1] of the buffered pc. It is 0 when fetch_ready = 0.
- BHT update on rob_br_valid: saturating ±1 on BHT[rob_br_pc index]. Taken increments toward 2'b11; not-taken decrements toward 2'b00.
  - An update in the same cycle as a lookup of the same index: the lookup sees the pre-update value.
  - Updates are applied even in a rob_clear cycle.
- PC arithmetic is 32-bit modulo; pc+4 wraps from 32'hFFFFFFFC to 0. The low two address bits are not checked.
- JALR is not redirected here; it falls through to pc+4 and is corrected by rob_clear.
- Reset asserted mid-request: return to reset values. The next icache response is not expected; the icache is reset by the same signal.

Decomposition:
- Shared package: opcode constants (branch/JAL/JALR), BHT counter width and reset value, fetch state enum {FETCH, HOLD, DROP}.
- One natural sub-module: branch_predictor (BHT array, combinational lookup port, synchronous update port).

Test Plan:
- Reset with RESET_PC = 0, then icache_valid with data 32'h00000013 in cycle 2 → fetch_ready = 1, pc = 0, inst = 32'h00000013, pred_res = 0; next request address = 4 after issue_ready.
- Decoder stall: hold issue_ready = 0 for 5 cycles in HOLD → inst/pc stable, icache_req = 0; issue_ready then gives icache_addr = pc+4.
- Redirect: issue_ready = 1 with pc_change_flag = 1 and pc_change = 32'h1000 → next icache_addr = 32'h1000.
- Flush mid-request: rob_clear with rob_clear_pc = 32'h200 while in FETCH at 32'h40, response arrives 3 cycles later → data discarded, fetch_ready stays 0, next request address = 32'h200.
- BHT training: two rob_br_valid taken updates for pc 32'h80 → the next buffered instruction at 32'h80 shows pred_res = 1. Two not-taken updates → pred_res = 0. A third taken update then saturates without wrapping.
- rdy_in low for 3 cycles while icache_valid pulses → no state change, no capture.
